// File: rtl/iob_cache_replacement_ctrl.sv
// rtl/iob_cache_replacement_ctrl.sv - replacement-policy port sequencer and arbiter for hit updates and victim allocation
module iob_cache_replacement_ctrl #(
    parameter int N_WAYS     = 8,
    parameter int NLINES_W   = 7,
    parameter int NWAYS_W    = $clog2(N_WAYS),
    parameter int STARVE_MAX = 4
) (
    input  logic                clk_i,
    input  logic                arst_i,
    input  logic                cke_i,
    input  logic                upd_valid_i,
    output logic                upd_ready_o,
    input  logic [NLINES_W-1:0] upd_line_i,
    input  logic [N_WAYS-1:0]   upd_way_i,
    input  logic                alloc_valid_i,
    output logic                alloc_ready_o,
    input  logic [NLINES_W-1:0] alloc_line_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [N_WAYS-1:0]   rsp_way_o,
    output logic [NWAYS_W-1:0]  rsp_way_bin_o,
    output logic                pol_we_o,
    output logic [NLINES_W-1:0] pol_line_o,
    output logic [N_WAYS-1:0]   pol_way_hit_o,
    input  logic [N_WAYS-1:0]   pol_way_select_i,
    input  logic [NWAYS_W-1:0]  pol_way_select_bin_i
);

    localparam int SC_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, ALLOC_RD, ALLOC_WR, RSP} state_t;

    state_t              state;
    logic [NLINES_W-1:0] q_line [2];
    logic [N_WAYS-1:0]   q_way  [2];
    logic                rd_ptr;
    logic                wr_ptr;
    logic [1:0]          q_cnt;
    logic [SC_W-1:0]     starve_cnt;
    logic [NLINES_W-1:0] alloc_line_r;
    logic [N_WAYS-1:0]   rsp_way_r;
    logic [NWAYS_W-1:0]  rsp_way_bin_r;
    logic                rsp_valid_r;

    logic q_full;
    logic q_empty;
    logic push;
    logic upd_win;
    logic pop;
    logic alloc_take;

    // Full flag comes from the registered count, so a full queue never passes through
    assign q_full      = (q_cnt == 2'd2);
    assign q_empty     = (q_cnt == 2'd0);
    assign upd_ready_o = !q_full && cke_i;
    assign push        = cke_i && upd_valid_i && !q_full && (|upd_way_i);

    // Updates win the port unless an allocation has been held off STARVE_MAX writes
    assign upd_win       = (state == IDLE) && !q_empty &&
                           (!alloc_valid_i || (starve_cnt < SC_W'(STARVE_MAX)));
    assign pop           = cke_i && upd_win;
    assign alloc_take    = cke_i && (state == IDLE) && alloc_valid_i && !upd_win;
    assign alloc_ready_o = alloc_take;

    assign rsp_valid_o   = rsp_valid_r && cke_i;
    assign rsp_way_o     = rsp_way_r;
    assign rsp_way_bin_o = rsp_way_bin_r;

    // Policy port mux: queued hit writes in IDLE, victim read then MRU commit during allocation
    always_comb begin
        pol_we_o      = 1'b0;
        pol_line_o    = '0;
        pol_way_hit_o = '0;
        case (state)
            IDLE: begin
                if (pop) begin
                    pol_we_o      = 1'b1;
                    pol_line_o    = q_line[rd_ptr];
                    pol_way_hit_o = q_way[rd_ptr];
                end
            end
            ALLOC_RD: pol_line_o = alloc_line_r;
            ALLOC_WR: begin
                pol_we_o      = cke_i;
                pol_line_o    = alloc_line_r;
                pol_way_hit_o = rsp_way_r;
            end
            default: ;
        endcase
    end

    // Two-entry hit-update FIFO; ways of zero are dropped at the door
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            q_line[0] <= '0;
            q_line[1] <= '0;
            q_way[0]  <= '0;
            q_way[1]  <= '0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            q_cnt     <= 2'd0;
        end else begin
            if (push) begin
                q_line[wr_ptr] <= upd_line_i;
                q_way[wr_ptr]  <= upd_way_i;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            q_cnt <= q_cnt + 2'(push) - 2'(pop);
        end
    end

    // Allocation sequencer with starvation counter and registered response
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state         <= IDLE;
            starve_cnt    <= '0;
            alloc_line_r  <= '0;
            rsp_way_r     <= '0;
            rsp_way_bin_r <= '0;
            rsp_valid_r   <= 1'b0;
        end else if (cke_i) begin
            case (state)
                IDLE: begin
                    if (!alloc_valid_i) begin
                        starve_cnt <= '0;
                    end else if (pop) begin
                        starve_cnt <= starve_cnt + SC_W'(1);
                    end else begin
                        starve_cnt   <= '0;
                        alloc_line_r <= alloc_line_i;
                        state        <= ALLOC_RD;
                    end
                end
                ALLOC_RD: begin
                    rsp_way_r     <= pol_way_select_i;
                    rsp_way_bin_r <= pol_way_select_bin_i;
                    state         <= ALLOC_WR;
                end
                ALLOC_WR: begin
                    rsp_valid_r <= 1'b1;
                    state       <= RSP;
                end
                RSP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_r <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
